// File: rtl/powerup_ctrl.sv
// Power-up sprite controller.
// Once per frame it moves the sprite through its life: hidden, spawn at a
// pseudo-random x, fall, rest on the ground, expire. A player whose hitbox
// overlaps the sprite collects it, and that is reported with a one-cycle grab pulse.
module powerup_ctrl #(
    parameter int V_SIZE         = 16,
    parameter int H_SIZE         = 16,
    parameter int P_SIZE         = 64,
    parameter int X_MIN          = 64,
    parameter int GROUND_Y       = 416,
    parameter int FALL_STEP      = 2,
    parameter int RESPAWN_FRAMES = 300,
    parameter int LIFE_FRAMES    = 600,
    parameter int PARK           = 2032
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [10:0] p1_x0,
    input  logic [10:0] p1_y0,
    input  logic [10:0] p2_x0,
    input  logic [10:0] p2_y0,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic        active,
    output logic        grab,
    output logic        grab_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FALL   = 2'd1;
    localparam logic [1:0] ST_LANDED = 2'd2;

    localparam int RC_W = $clog2(RESPAWN_FRAMES);
    localparam int LC_W = $clog2(LIFE_FRAMES);

    // Bounding-box arithmetic is carried in 12 bits so edge sums never wrap.
    localparam logic [11:0] H12      = 12'(H_SIZE);
    localparam logic [11:0] V12      = 12'(V_SIZE);
    localparam logic [11:0] P12      = 12'(P_SIZE);
    localparam logic [11:0] STEP12   = 12'(FALL_STEP);
    localparam logic [11:0] LAND_Y12 = 12'(GROUND_Y - V_SIZE);
    localparam logic [10:0] PARK11   = 11'(PARK);

    localparam logic [RC_W-1:0] RESPAWN_LAST = RC_W'(RESPAWN_FRAMES - 1);
    localparam logic [LC_W-1:0] LIFE_LAST    = LC_W'(LIFE_FRAMES - 1);

    logic [1:0]      state_reg;
    logic [RC_W-1:0] respawn_cnt_reg;
    logic [LC_W-1:0] life_cnt_reg;
    logic [9:0]      lfsr_reg;

    logic [10:0] px [2];
    logic [10:0] py [2];
    logic [1:0]  hit;
    logic [11:0] y_next;
    logic [10:0] spawn_x;

    assign px[0] = p1_x0;
    assign py[0] = p1_y0;
    assign px[1] = p2_x0;
    assign py[1] = p2_y0;

    assign y_next  = {1'b0, y0} + STEP12;
    assign spawn_x = 11'(X_MIN) + {2'b00, lfsr_reg[8:0]};

    // Per-player hitbox overlap against the sprite's current position.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit[gi] = ({1'b0, px[gi]} < ({1'b0, x0} + H12)) &&
                             ({1'b0, x0} < ({1'b0, px[gi]} + P12)) &&
                             ({1'b0, py[gi]} < ({1'b0, y0} + V12)) &&
                             ({1'b0, y0} < ({1'b0, py[gi]} + P12));
        end
    endgenerate

    // Free-running x^10 + x^7 + 1 LFSR supplying the spawn column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= 10'h001;
        end else begin
            lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
        end
    end

    // Frame-rate lifecycle: idle countdown, fall, ground life, pickup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            x0              <= PARK11;
            y0              <= PARK11;
            active          <= 1'b0;
            grab            <= 1'b0;
            grab_id         <= 1'b0;
            respawn_cnt_reg <= '0;
            life_cnt_reg    <= '0;
        end else begin
            grab <= 1'b0;
            if (!enable) begin
                state_reg       <= ST_IDLE;
                x0              <= PARK11;
                y0              <= PARK11;
                active          <= 1'b0;
                respawn_cnt_reg <= '0;
                life_cnt_reg    <= '0;
            end else if (frame_tick) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (respawn_cnt_reg == RESPAWN_LAST) begin
                            state_reg       <= ST_FALL;
                            x0              <= spawn_x;
                            y0              <= '0;
                            active          <= 1'b1;
                            respawn_cnt_reg <= '0;
                        end else begin
                            respawn_cnt_reg <= respawn_cnt_reg + 1'b1;
                        end
                    end
                    ST_FALL, ST_LANDED: begin
                        if (hit != 2'b00) begin
                            // Player 1 wins a simultaneous pickup.
                            grab            <= 1'b1;
                            grab_id         <= ~hit[0];
                            state_reg       <= ST_IDLE;
                            x0              <= PARK11;
                            y0              <= PARK11;
                            active          <= 1'b0;
                            respawn_cnt_reg <= '0;
                            life_cnt_reg    <= '0;
                        end else if (state_reg == ST_FALL) begin
                            if (y_next >= LAND_Y12) begin
                                y0           <= LAND_Y12[10:0];
                                state_reg    <= ST_LANDED;
                                life_cnt_reg <= '0;
                            end else begin
                                y0 <= y_next[10:0];
                            end
                        end else if (life_cnt_reg == LIFE_LAST) begin
                            state_reg    <= ST_IDLE;
                            x0           <= PARK11;
                            y0           <= PARK11;
                            active       <= 1'b0;
                            life_cnt_reg <= '0;
                        end else begin
                            life_cnt_reg <= life_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        x0        <= PARK11;
                        y0        <= PARK11;
                        active    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_powerup_ctrl.sv
// Self-checking bench for powerup_ctrl against a frame-level behavioural model.
module tb_powerup_ctrl;

    localparam int PARK   = 2032;
    localparam int LAND_Y = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] p1_x0 = '0, p1_y0 = '0, p2_x0 = '0, p2_y0 = '0;
    logic [10:0] x0, y0;
    logic        active, grab, grab_id;

    int checks = 0;
    int failures = 0;

    // Model state: phase 0 = hidden, 1 = falling, 2 = on ground.
    int   m_phase, m_x, m_y, m_cnt;
    bit   m_grab, m_gid;
    logic [9:0] m_lfsr;

    powerup_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .p1_x0(p1_x0), .p1_y0(p1_y0), .p2_x0(p2_x0), .p2_y0(p2_y0),
        .x0(x0), .y0(y0), .active(active), .grab(grab), .grab_id(grab_id)
    );

    always #5 clk = ~clk;

    // Pseudo-random source: polynomial x^10 + x^7 + 1, one step per clock.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 10'h001;
        else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic bit hits(int px, int py, int sx, int sy);
        return (px < sx + 16) && (sx < px + 64) && (py < sy + 16) && (sy < py + 64);
    endfunction

    task automatic model_park();
        m_phase = 0; m_x = PARK; m_y = PARK; m_cnt = 0;
    endtask

    task automatic model_reset();
        model_park(); m_grab = 0; m_gid = 0;
    endtask

    // Frame-level behaviour for one tick, using pre-edge inputs.
    task automatic model_tick();
        m_grab = 0;
        if (!enable) begin
            model_park();
        end else if (m_phase == 0) begin
            m_cnt++;
            if (m_cnt == 300) begin
                m_phase = 1; m_x = 64 + int'(m_lfsr[8:0]); m_y = 0; m_cnt = 0;
            end
        end else if (hits(int'(p1_x0), int'(p1_y0), m_x, m_y)) begin
            m_grab = 1; m_gid = 0; model_park();
        end else if (hits(int'(p2_x0), int'(p2_y0), m_x, m_y)) begin
            m_grab = 1; m_gid = 1; model_park();
        end else if (m_phase == 1) begin
            m_y = (m_y + 2 >= LAND_Y) ? LAND_Y : m_y + 2;
            if (m_y == LAND_Y) begin m_phase = 2; m_cnt = 0; end
        end else begin
            m_cnt++;
            if (m_cnt == 600) model_park();
        end
    endtask

    // One frame tick followed by 1-2 quiet cycles; outputs checked after each edge.
    task automatic tick();
        int gap;
        gap = $urandom_range(1, 2);
        @(negedge clk);
        frame_tick = 1'b1;
        model_tick();
        @(posedge clk); #1;
        frame_tick = 1'b0;
        checks++;
        if (x0 !== 11'(m_x) || y0 !== 11'(m_y) || active !== (m_phase != 0) ||
            grab !== m_grab || (m_grab && grab_id !== m_gid)) begin
            failures++;
            $display("FAIL tick_outputs: got x0=%0d y0=%0d active=%0b grab=%0b id=%0b, expected x0=%0d y0=%0d active=%0b grab=%0b id=%0b",
                     x0, y0, active, grab, grab_id, m_x, m_y, m_phase != 0, m_grab, m_gid);
        end
        m_grab = 0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            checks++;
            if (grab !== 1'b0 || grab_id !== m_gid || x0 !== 11'(m_x) || y0 !== 11'(m_y)) begin
                failures++;
                $display("FAIL idle_hold: got grab=%0b id=%0b x0=%0d y0=%0d, expected grab=0 id=%0b x0=%0d y0=%0d",
                         grab, grab_id, x0, y0, m_gid, m_x, m_y);
            end
        end
    endtask

    task automatic players_away();
        p1_x0 = '0; p1_y0 = '0; p2_x0 = '0; p2_y0 = '0;
    endtask

    // Tick until the sprite spawns; bounded.
    task automatic run_to_spawn();
        int n = 0;
        while (m_phase != 1 && n < 400) begin tick(); n++; end
        checks++;
        if (m_phase != 1 || active !== 1'b1) begin
            failures++;
            $display("FAIL spawn_timeout: active=%0b after %0d ticks, expected 1", active, n);
        end
    endtask

    task automatic fall_to(int y);
        int n = 0;
        while (m_phase == 1 && m_y != y && n < 250) begin tick(); n++; end
        checks++;
        if (y0 !== 11'(y)) begin
            failures++;
            $display("FAIL fall_to: y0=%0d, expected %0d", y0, y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; players_away();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (x0 !== 11'd2032 || y0 !== 11'd2032 || active !== 1'b0 || grab !== 1'b0 || grab_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: x0=%0d y0=%0d active=%0b grab=%0b id=%0b, expected 2032 2032 0 0 0",
                     x0, y0, active, grab, grab_id);
        end
        @(negedge clk); reset = 1'b0; enable = 1'b1;
    endtask

    task automatic test_spawn_fall_land();
        int xs;
        for (int i = 0; i < 299; i++) tick();
        checks++;
        if (x0 !== 11'd2032 || active !== 1'b0) begin
            failures++;
            $display("FAIL pre_spawn: x0=%0d active=%0b, expected 2032 0", x0, active);
        end
        tick();
        xs = int'(x0);
        checks++;
        if (y0 !== 11'd0 || active !== 1'b1 || xs < 64 || xs > 575) begin
            failures++;
            $display("FAIL spawn: x0=%0d y0=%0d active=%0b, expected 64..575 0 1", x0, y0, active);
        end
        for (int i = 0; i < 200; i++) tick();
        checks++;
        if (y0 !== 11'd400 || m_phase != 2) begin
            failures++;
            $display("FAIL landing: y0=%0d, expected 400 on ground", y0);
        end
        for (int i = 0; i < 599; i++) tick();
        checks++;
        if (active !== 1'b1 || y0 !== 11'd400) begin
            failures++;
            $display("FAIL ground_life: active=%0b y0=%0d, expected 1 400", active, y0);
        end
        tick();
        checks++;
        if (x0 !== 11'd2032 || y0 !== 11'd2032 || active !== 1'b0) begin
            failures++;
            $display("FAIL expiry: x0=%0d y0=%0d active=%0b, expected 2032 2032 0", x0, y0, active);
        end
    endtask

    task automatic test_grab_p1();
        int n;
        run_to_spawn();
        fall_to(100);
        @(negedge clk);
        p1_x0 = x0 - 11'd10; p1_y0 = 11'd60;
        tick();
        checks++;
        if (m_grab == 0 && m_x != PARK) begin
            failures++;
            $display("FAIL p1_grab_model: sprite x0=%0d still live, expected pickup", x0);
        end
        players_away();
        n = 0;
        while (active !== 1'b1 && n < 320) begin tick(); n++; end
        checks++;
        if (n != 300) begin
            failures++;
            $display("FAIL respawn_delay: spawned after %0d ticks, expected 300", n);
        end
    endtask

    // Directed pickup check for a chosen set of overlapping players.
    task automatic grab_with(bit use_p1, bit use_p2, int at_y, bit exp_id);
        run_to_spawn();
        fall_to(at_y);
        @(negedge clk);
        if (use_p1) begin p1_x0 = x0; p1_y0 = y0; end
        if (use_p2) begin p2_x0 = x0 + 11'd3; p2_y0 = y0 + 11'd2; end
        @(negedge clk);
        frame_tick = 1'b1;
        model_tick();
        @(posedge clk); #1;
        frame_tick = 1'b0;
        checks++;
        if (grab !== 1'b1 || grab_id !== exp_id || y0 !== 11'd2032 || active !== 1'b0) begin
            failures++;
            $display("FAIL grab_pick: grab=%0b id=%0b y0=%0d active=%0b, expected 1 %0b 2032 0",
                     grab, grab_id, y0, active, exp_id);
        end
        m_grab = 0;
        @(posedge clk); #1;
        checks++;
        if (grab !== 1'b0 || grab_id !== exp_id || x0 !== 11'd2032) begin
            failures++;
            $display("FAIL grab_single: grab=%0b id=%0b x0=%0d, expected 0 %0b 2032", grab, grab_id, x0, exp_id);
        end
        players_away();
    endtask

    task automatic test_both_players();
        grab_with(1'b1, 1'b1, 20, 1'b0);
        grab_with(1'b0, 1'b1, 40, 1'b1);
    endtask

    task automatic test_grab_beats_landing();
        grab_with(1'b0, 1'b1, 398, 1'b1);
    endtask

    task automatic test_enable_drop();
        run_to_spawn();
        fall_to(400);
        for (int i = 0; i < 25; i++) tick();
        @(negedge clk);
        enable = 1'b0;
        model_park();
        @(posedge clk); #1;
        checks++;
        if (x0 !== 11'd2032 || y0 !== 11'd2032 || active !== 1'b0 || grab !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop: x0=%0d y0=%0d active=%0b grab=%0b, expected 2032 2032 0 0",
                     x0, y0, active, grab);
        end
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        enable = 1'b1;
        run_to_spawn();
    endtask

    task automatic test_reset_mid_fall();
        fall_to(60);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (x0 !== 11'd2032 || y0 !== 11'd2032 || active !== 1'b0 || grab !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: x0=%0d y0=%0d active=%0b grab=%0b, expected 2032 2032 0 0",
                     x0, y0, active, grab);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Random player motion, with frequent placements close to the sprite.
    task automatic test_random();
        int dx, dy;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (m_phase != 0 && $urandom_range(0, 7) == 0) begin
                dx = m_x + $signed($urandom_range(0, 100)) - 70;
                dy = m_y + $signed($urandom_range(0, 100)) - 70;
                if (dx < 0) dx = 0;
                if (dy < 0) dy = 0;
                if ($urandom_range(0, 1) == 0) begin p1_x0 = 11'(dx); p1_y0 = 11'(dy); end
                else                           begin p2_x0 = 11'(dx); p2_y0 = 11'(dy); end
            end else if ($urandom_range(0, 15) == 0) begin
                p1_x0 = 11'($urandom_range(0, 2047)); p1_y0 = 11'($urandom_range(0, 2047));
                p2_x0 = 11'($urandom_range(0, 2047)); p2_y0 = 11'($urandom_range(0, 2047));
            end
            tick();
        end
        players_away();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_spawn_fall_land();
        test_grab_p1();
        test_both_players();
        test_grab_beats_landing();
        test_enable_drop();
        test_reset_mid_fall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/powerup_ctrl.md
Name: powerup_ctrl

Overview:
- Upstream controller for the power-up sprite source. Drives the sprite's top-left corner (x0, y0) once per video frame.
- Lifecycle: hidden → spawns at a pseudo-random x at the top of the screen → falls at a fixed rate → rests on the ground → expires, unless a player grabs it first.
- Reports grabs to the game-logic register interface.

Parameters:
- V_SIZE, 16, sprite height in pixels.
- H_SIZE, 16, sprite width in pixels.
- P_SIZE, 64, player hitbox edge (square) in pixels.
- X_MIN, 64, leftmost spawn x. Spawn x = X_MIN + lfsr[8:0], so the range is X_MIN..X_MIN+511.
- GROUND_Y, 416, ground line y. Landing y0 is LAND_Y = GROUND_Y − V_SIZE.
- FALL_STEP, 2, pixels dropped per frame.
- RESPAWN_FRAMES, 300, frames spent hidden before each spawn.
- LIFE_FRAMES, 600, frames the power-up remains on the ground.
- PARK, 2032, off-screen x0/y0 value used while hidden.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  single-cycle pulse, once per frame (start of vertical blank).
- enable  in  1  game running. Low forces the hidden state.
- p1_x0, p1_y0  in  11 each  player-1 hitbox top-left.
- p2_x0, p2_y0  in  11 each  player-2 hitbox top-left.
- x0, y0  out  11 each  sprite origin, registered.
- active  out  1  high while the power-up is visible (FALL or LANDED).
- grab  out  1  one-cycle pulse when a player collects the power-up.
- grab_id  out  1  0 = player 1, 1 = player 2. Valid with grab; holds its value otherwise.

Behaviour:
- Clock and reset: one clock, `clk`; reset `reset` is asynchronous and active-high.
- Reset values: state = IDLE, x0 = y0 = PARK, active = 0, grab = 0, grab_id = 0, respawn_cnt = 0, life_cnt = 0, lfsr = 10'h001.
- LFSR:
  - 10-bit Fibonacci, taps x^10 + x^7 + 1. Advances every clk, independent of enable.
  - The zero state is unreachable from reset.
- State changes only on clk edges where frame_tick = 1. All outputs are registered and take effect on the edge sampling the tick.
- States:
  - IDLE:
    - x0 = y0 = PARK, active = 0.
    - On each tick, respawn_cnt increments.
    - On the tick where respawn_cnt == RESPAWN_FRAMES−1: go to FALL, x0 = X_MIN + lfsr[8:0], y0 = 0, respawn_cnt cleared.
  - FALL (active = 1):
    - On a tick, compute y_next = y0 + FALL_STEP in 12-bit unsigned.
    - If y_next ≥ LAND_Y: y0 = LAND_Y (clamped, never overshoots), go to LANDED, life_cnt = 0.
    - Otherwise y0 = y_next.
  - LANDED (active = 1):
    - On each tick, life_cnt increments.
    - On the tick where life_cnt == LIFE_FRAMES−1: go to IDLE, park, active = 0.
- Pickup:
  - Evaluated on every tick in FALL or LANDED, using the current (pre-update) x0/y0.
  - Player n overlaps when all four hold, in 12-bit unsigned: pn_x0 < x0+H_SIZE, x0 < pn_x0+P_SIZE, pn_y0 < y0+V_SIZE, y0 < pn_y0+P_SIZE.
  - On overlap: grab = 1 for exactly one cycle, grab_id set, go to IDLE, park, respawn_cnt = 0.
  - Pickup has priority over landing and expiry on the same tick.
  - Both players overlapping on the same tick: player 1 wins, grab_id = 0.
- Pickup is never evaluated in IDLE. A parked sprite cannot be grabbed.
- enable = 0:
  - Takes effect on the next clk edge, tick or not.
  - Forces IDLE, park, active = 0, respawn_cnt = 0, life_cnt = 0. No grab is issued.
  - Counting resumes on the first tick after enable returns high.
- frame_tick held high for more than one cycle is illegal; behaviour is unspecified.
- Asserting reset mid-FALL or mid-LANDED parks immediately (asynchronously) with no grab pulse.

Test Plan:
- Reset, then enable = 1, players far away (p1 = p2 = (0,0)). Apply 299 ticks → x0 = 2032, active = 0. Tick 300 → y0 = 0, active = 1, 64 ≤ x0 ≤ 575.
- Continue ticks → y0 steps 0, 2, 4, … On tick 200 of FALL, y0 = 400 = LAND_Y exactly and the state is LANDED. On LANDED tick 600 → x0 = y0 = 2032, active = 0, grab never pulsed.
- In FALL at y0 = 100, set p1 = (x0−10, 60) and tick → grab = 1 for one cycle, grab_id = 0, next cycle x0 = 2032. The next spawn occurs exactly 300 ticks later.
- Both players overlapping the sprite on the same tick → single grab pulse, grab_id = 0. Repeat with only p2 overlapping → grab_id = 1.
- Sprite at y0 = 398 and p2 overlapping on the same tick → grab wins: grab = 1, state IDLE, y0 never shows 400.
- Drop enable mid-LANDED → park on the next cycle with no tick required. Assert reset mid-FALL → outputs park asynchronously, grab = 0.
